// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle fetch/decode/execute/writeback sequencer driving a combinational ALU
// from a 4x16 register file, with one instruction in flight at a time.
module alu_issue_ctrl #(
  parameter int          PC_W    = 8,
  parameter logic [7:0]  HALT_OP = 8'hFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [15:0]     alu_instr,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  output logic            alu_cin,
  input  logic [15:0]     alu_result,
  input  logic            alu_carry,
  output logic            carry_flag,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  input  logic [1:0]      dbg_sel,
  output logic [15:0]     dbg_data
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;
  state_t          state_q;
  logic [15:0]     ir_q, res_q, instr_q, a_q, b_q;
  logic [15:0]     rf_q [4];
  logic            c_q, carry_q, req_q, halted_q;
  logic [PC_W-1:0] pc_q;
  logic            wr_op;
  // ops F8..FD write the destination register; everything else is a NOP
  assign wr_op = ir_q[15:8] inside {[8'hF8:8'hFD]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      res_q    <= '0;
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      carry_q  <= 1'b0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      pc_q     <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (run) begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: if (imem_ack) begin
          ir_q    <= imem_data;
          pc_q    <= pc_q + PC_W'(1);
          req_q   <= 1'b0;
          state_q <= DECODE;
        end
        DECODE: if (ir_q[15:8] == HALT_OP) begin
          state_q  <= HALT;
          halted_q <= 1'b1;
        end else begin
          instr_q <= ir_q;
          a_q     <= rf_q[ir_q[5:4]];
          b_q     <= rf_q[ir_q[3:2]];
          state_q <= EXEC;
        end
        EXEC: begin
          res_q   <= alu_result;
          c_q     <= alu_carry;
          state_q <= WB;
        end
        WB: begin
          if (wr_op) rf_q[ir_q[7:6]] <= res_q;
          if (wr_op && ir_q[1] && ir_q[15:8] != 8'hFC) carry_q <= c_q;
          state_q <= run ? FETCH : IDLE;
          req_q   <= run;
        end
        HALT: halted_q <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign alu_instr  = instr_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_cin    = carry_q;
  assign carry_flag = carry_q;
  assign halted     = halted_q;
  assign dbg_data   = rf_q[dbg_sel];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with an ALU stub, a reference register-file model
// and a scoreboard of expected writeback results checked after each instruction.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic [1:0]  dbg_sel = '0;
  logic        imem_req, alu_cin, alu_carry, carry_flag, halted;
  logic [7:0]  imem_addr, pc;
  logic [15:0] alu_instr, alu_a, alu_b, alu_result, dbg_data;
  logic [15:0] alu_inp = '0;
  logic [15:0] m_r [4];
  logic        m_c;
  logic [7:0]  m_pc;
  int          vectors = 0, miscompares = 0;
  typedef struct {logic [1:0] rd; logic [15:0] val; logic c; int cyc;} exp_t;
  exp_t sbq[$];

  alu_issue_ctrl #(.PC_W(8), .HALT_OP(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .alu_instr(alu_instr), .alu_a(alu_a),
    .alu_b(alu_b), .alu_cin(alu_cin), .alu_result(alu_result), .alu_carry(alu_carry),
    .carry_flag(carry_flag), .pc(pc), .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] alu_f(input logic [15:0] i, a, b, input logic cin,
                                        input logic [15:0] inp);
    logic [16:0] ci;
    ci = {16'b0, cin & i[0]};
    case (i[15:8])
      8'hF8:   return {1'b0, a} + {1'b0, b} + ci;
      8'hF9:   return {1'b0, a} - {1'b0, b} - ci;
      8'hFA:   return {1'b0, a} + 17'd1;
      8'hFB:   return {1'b0, a} - 17'd1;
      8'hFC:   return {1'b0, inp};
      8'hFD:   return {1'b0, a * b};
      default: return 17'd0;
    endcase
  endfunction

  always_comb {alu_carry, alu_result} = alu_f(alu_instr, alu_a, alu_b, alu_cin, alu_inp);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1 chk("dbg_reg", dbg_data, m_r[i]);
    end
    chk("carry_flag", carry_flag, m_c);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    @(negedge clk);
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", imem_req, 1);
    chk("imem_addr", imem_addr, m_pc);
    m_pc++;
  endtask

  task automatic issue(input logic [15:0] w, input int waits, input bit keep_run);
    logic [16:0] r;
    exp_t e;
    int n;
    r = alu_f(w, m_r[w[5:4]], m_r[w[3:2]], m_c, alu_inp);
    if (w[15:8] inside {[8'hF8:8'hFD]}) begin
      m_r[w[7:6]] = r[15:0];
      if (w[1] && w[15:8] != 8'hFC) m_c = r[16];
    end
    e = '{w[7:6], m_r[w[7:6]], m_c, 4 + waits};
    sbq.push_back(e);
    wait_req();
    repeat (waits) begin
      @(negedge clk);
      chk("req_held", imem_req, 1);
    end
    imem_ack = 1'b1;
    imem_data = w;
    n = waits;
    @(negedge clk);
    imem_ack = 1'b0;
    n++;
    if (!keep_run) run = 1'b0;
    if (keep_run) begin
      while (!imem_req && n < 60) begin
        @(negedge clk);
        n++;
      end
    end else repeat (3) @(negedge clk);
    e = sbq.pop_front();
    if (keep_run) chk("cycles", n, e.cyc);
    else chk("idle_after_drop", imem_req, 0);
    dbg_sel = e.rd;
    #1 chk("wb_value", dbg_data, e.val);
    chk("wb_carry", carry_flag, e.c);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    m_r = '{default: 16'h0};
    m_c = 1'b0;
    m_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instr", alu_instr, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    check_regs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_req", imem_req, 0);
    run = 1'b1;
    // load and add, zero-wait memory
    alu_inp = 16'd5;    issue(16'hFC40, 0, 1);
    alu_inp = 16'd3;    issue(16'hFC80, 0, 1);
    issue(16'hF8DA, 0, 1);
    check_regs();
    // carry out, then carry in
    alu_inp = 16'hFFFF; issue(16'hFC40, 0, 1);
    alu_inp = 16'h0001; issue(16'hFC80, 0, 1);
    issue(16'hF8DA, 0, 1);
    issue(16'hF8DB, 0, 1);
    check_regs();
    // decrement with and without carry enable
    alu_inp = 16'h0000; issue(16'hFC40, 0, 1);
    issue(16'hFB12, 0, 1);
    alu_inp = 16'h0001; issue(16'hFC40, 0, 1);
    issue(16'hFB10, 0, 1);
    issue(16'hF9DB, 0, 1);
    issue(16'h1234, 0, 1);
    check_regs();
    // slow memory
    alu_inp = 16'd5;    issue(16'hFC40, 3, 1);
    alu_inp = 16'd3;    issue(16'hFC80, 3, 1);
    issue(16'hF8DA, 3, 1);
    check_regs();
    // run dropped mid-instruction
    issue(16'hFA46, 0, 0);
    repeat (3) @(negedge clk);
    chk("idle_hold", imem_req, 0);
    run = 1'b1;
    // pc wrap
    while (m_pc != 8'hFF) issue(16'h0000, 0, 1);
    issue(16'h0000, 0, 1);
    issue(16'h0000, 0, 1);
    chk("pc_after_wrap", pc, 1);
    // reset during EXEC
    wait_req();
    imem_ack = 1'b1;
    imem_data = 16'hF8DA;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    m_r = '{default: 16'h0};
    m_c = 1'b0;
    m_pc = '0;
    #1;
    chk("abort_pc", pc, 0);
    chk("abort_req", imem_req, 0);
    chk("abort_instr", alu_instr, 0);
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_data = 16'hFC40;
    repeat (2) @(negedge clk);
    imem_ack = 1'b0;
    chk("idle_ack_pc", pc, 0);
    chk("idle_ack_req", imem_req, 0);
    check_regs();
    run = 1'b1;
    // halt at address 2
    alu_inp = 16'd7;    issue(16'hFC40, 0, 1);
    alu_inp = 16'd9;    issue(16'hFC80, 0, 1);
    wait_req();
    imem_ack = 1'b1;
    imem_data = 16'hFF00;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("halt_decode", halted, 0);
    @(negedge clk);
    chk("halted", halted, 1);
    chk("halt_pc", pc, 3);
    imem_ack = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("halt_req", imem_req, 0);
      chk("halt_stays", halted, 1);
    end
    imem_ack = 1'b0;
    chk("halt_pc_final", pc, 3);
    check_regs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
